// File: rtl/pmem_responder.sv
// ---------------------------------------------------------------------------
// pmem_responder
//
// Purpose:
//   Behavioural model of a line-oriented physical memory. The memory answers
//   256-bit line read and write requests after a fixed latency. It accepts
//   one request at a time. The initiator holds a request until it sees
//   pmem_resp. That response is a single-cycle pulse in cycle T+LATENCY,
//   where T is the cycle in which the request was captured.
//
// Parameters:
//   LATENCY  cycles from request capture to pmem_resp (1..255)
//   LINES    number of 256-bit lines (power of two, >= 2)
//
// Ports:
//   clk           single clock, rising-edge
//   rst           asynchronous active-low reset
//   pmem_address  byte address; line index = pmem_address[5 +: log2(LINES)]
//   pmem_read     line read request (held until pmem_resp)
//   pmem_write    line write request (held until pmem_resp); wins over read
//   pmem_wdata    write line data
//   pmem_rdata    registered read data; holds until the next read completes
//   pmem_resp     one-cycle completion pulse
//   protocol_err  sticky initiator protocol violation flag
//
// Configuration:
//   PMEM_PROTOCOL_CHECK_EN  when defined, enables the protocol checker that
//                           drives protocol_err. When undefined,
//                           protocol_err is tied low. The data path and the
//                           timing are the same in both builds.
// ---------------------------------------------------------------------------
module pmem_responder #(
    parameter int LATENCY = 4,
    parameter int LINES   = 256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  pmem_address,
    input  logic         pmem_read,
    input  logic         pmem_write,
    input  logic [255:0] pmem_wdata,
    output logic [255:0] pmem_rdata,
    output logic         pmem_resp,
    output logic         protocol_err
);

    localparam int         IDX_W        = $clog2(LINES);
    localparam bit         SINGLE_CYCLE = (LATENCY == 1);
    // The WAIT state is visited LATENCY-1 times, so the counter starts at LATENCY-2.
    localparam logic [7:0] CNT_LOAD     = (LATENCY >= 2) ? 8'(LATENCY - 2) : 8'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [7:0]       cnt;
    logic [IDX_W-1:0] cap_idx;
    logic             cap_write;
    logic [255:0]     cap_wdata;
    logic [255:0]     mem [LINES];

    logic             req;
    logic [IDX_W-1:0] addr_idx;
    logic             enter_resp;
    logic [IDX_W-1:0] resp_idx;
    logic             resp_is_read;
    logic             unused_addr_bits;

    assign req      = pmem_read | pmem_write;
    assign addr_idx = pmem_address[5 +: IDX_W];

    // Byte-offset bits are ignored. Bits above the index field are dropped,
    // so upper addresses alias onto the lower lines.
    assign unused_addr_bits = ^{pmem_address[4:0], pmem_address[31:5+IDX_W]};

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, whatever the process order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    // NOTE: next_state gets a default before the case so that no path leaves
    // it unassigned; an unassigned path would infer a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: if (req) next_state = SINGLE_CYCLE ? RESP : WAIT;
            WAIT: if (cnt == '0) next_state = RESP;
            RESP: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs
    // -----------------------------------------------------------------------
    always_comb begin
        pmem_resp = (state == RESP);
    end

    // On the edge into RESP, the request is the live input when coming from
    // IDLE (LATENCY=1) and the captured request when coming from WAIT.
    always_comb begin
        enter_resp   = (state != RESP) && (next_state == RESP);
        resp_idx     = (state == IDLE) ? addr_idx    : cap_idx;
        resp_is_read = (state == IDLE) ? !pmem_write : !cap_write;
    end

    // -----------------------------------------------------------------------
    // Request capture, latency counter, read data register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= '0;
            cap_idx    <= '0;
            cap_write  <= 1'b0;
            cap_wdata  <= '0;
            pmem_rdata <= '0;
        end else begin
            if (state == IDLE && req) begin
                cnt       <= CNT_LOAD;
                cap_idx   <= addr_idx;
                cap_write <= pmem_write;
                cap_wdata <= pmem_wdata;
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - 8'd1;
            end

            // Writes never touch pmem_rdata; it only reloads when a read completes.
            if (enter_resp && resp_is_read) begin
                pmem_rdata <= mem[resp_idx];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Line storage
    // -----------------------------------------------------------------------
    // NOTE: the storage array has no reset. A reset on every line would
    // stop it from mapping onto a RAM, and its contents are undefined until
    // the first write anyway. Reset forces the FSM to IDLE, so a reset during
    // a transaction still prevents the commit.
    always_ff @(posedge clk) begin
        if (state == RESP && cap_write) begin
            mem[cap_idx] <= cap_wdata;
        end
    end

    // -----------------------------------------------------------------------
    // Optional initiator protocol checker
    // -----------------------------------------------------------------------
`ifdef PMEM_PROTOCOL_CHECK_EN
    logic [26:0] cap_addr_hi;
    logic        busy;
    logic        req_broken;
    logic        viol;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_addr_hi <= '0;
        end else if (state == IDLE && req) begin
            cap_addr_hi <= pmem_address[31:5];
        end
    end

    // The held request must keep its opcode and stay asserted through RESP.
    always_comb begin
        busy       = (state == WAIT) || (state == RESP);
        req_broken = cap_write ? (!pmem_write || pmem_read)
                               : (!pmem_read  || pmem_write);
        viol       = (pmem_read && pmem_write)
                  || (busy && req_broken)
                  || (busy && (pmem_address[31:5] != cap_addr_hi))
                  || (busy && cap_write && (pmem_wdata != cap_wdata));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            protocol_err <= 1'b0;
        end else if (viol) begin
            protocol_err <= 1'b1;
        end
    end
`else
    assign protocol_err = 1'b0;
`endif

endmodule

// File: tb/tb_pmem_responder.sv
// ---------------------------------------------------------------------------
// tb_pmem_responder
//
// Instance dut: LATENCY=4, LINES=256. A scoreboard queue holds one entry per
// request, giving the cycle the response is due and the expected
// pmem_rdata. A monitor pops an entry on every pmem_resp pulse.
// Instance dut1: LATENCY=1, LINES=4. Directed checks of the single-cycle
// path and of a held request getting one response every two cycles.
// ---------------------------------------------------------------------------
module tb_pmem_responder;

    localparam int LAT = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  addr;
    logic         rd;
    logic         wr;
    logic [255:0] wdata;
    logic [255:0] rdata;
    logic         resp;
    logic         perr;

    logic [31:0]  b_addr;
    logic         b_rd;
    logic         b_wr;
    logic [255:0] b_wdata;
    logic [255:0] b_rdata;
    logic         b_resp;
    logic         b_perr;

    always #5 clk = ~clk;

    pmem_responder #(.LATENCY(LAT), .LINES(256)) dut (
        .clk          (clk),
        .rst          (rst),
        .pmem_address (addr),
        .pmem_read    (rd),
        .pmem_write   (wr),
        .pmem_wdata   (wdata),
        .pmem_rdata   (rdata),
        .pmem_resp    (resp),
        .protocol_err (perr)
    );

    pmem_responder #(.LATENCY(1), .LINES(4)) dut1 (
        .clk          (clk),
        .rst          (rst),
        .pmem_address (b_addr),
        .pmem_read    (b_rd),
        .pmem_write   (b_wr),
        .pmem_wdata   (b_wdata),
        .pmem_rdata   (b_rdata),
        .pmem_resp    (b_resp),
        .protocol_err (b_perr)
    );

    typedef struct {
        int           due;
        bit           is_read;
        logic [255:0] data;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_e;
    logic [255:0] model_mem [256];
    logic [255:0] last_rd;
    int           cyc   = 0;
    int           total = 0;
    int           bad   = 0;

`ifdef PMEM_PROTOCOL_CHECK_EN
    localparam logic EXP_BOTH_ERR = 1'b1;
`else
    localparam logic EXP_BOTH_ERR = 1'b0;
`endif

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor: each response pulse must match the oldest pending entry.
    always @(negedge clk) begin
        if (rst === 1'b1 && resp === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_resp", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("resp_cycle", mon_e.due, mon_e.due);
                check("resp_cycle", cyc, mon_e.due);
                if (mon_e.is_read) check("rdata", rdata, mon_e.data);
                else               check("rdata_hold", rdata, mon_e.data);
            end
        end
    end

    task automatic wait_resp(input string tag);
        bit got = 0;
        for (int i = 0; i < LAT + 4; i++) begin
            @(negedge clk);
            if (resp === 1'b1) begin
                got = 1;
                break;
            end
        end
        if (!got) check(tag, 0, 1);
    endtask

    // Drive one request from the next cycle on and hold it until its response.
    task automatic req(input bit is_wr, input bit both, input logic [31:0] a, input logic [255:0] d);
        exp_t e;
        int   idx;
        @(posedge clk); #1;
        addr  = a;
        wr    = is_wr;
        rd    = !is_wr || both;
        wdata = d;
        idx   = int'((a >> 5) & 32'hFF);
        e.due     = cyc + LAT;
        e.is_read = !is_wr;
        if (is_wr) begin
            e.data         = last_rd;
            model_mem[idx] = d;
        end else begin
            e.data  = model_mem[idx];
            last_rd = model_mem[idx];
        end
        sb.push_back(e);
        wait_resp(is_wr ? "wr_timeout" : "rd_timeout");
    endtask

    task automatic idle();
        @(posedge clk); #1;
        rd = 1'b0;
        wr = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] bx;
        rst = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        b_rd = 1'b0; b_wr = 1'b0; b_addr = '0; b_wdata = '0;
        last_rd = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_resp",  resp,  0);
        check("rst_rdata", rdata, 0);
        check("rst_perr",  perr,  0);
        check("rst_b_resp", b_resp, 0);
        rst = 1'b1;

        // Write at cycle 10 -> response at cycle 14; read back
        while (cyc < 9) begin @(posedge clk); #1; end
        req(1, 0, 32'h0000_0040, {32{8'hA5}});
        idle();
        req(0, 0, 32'h0000_0040, '0);
        idle();

        // Write line 3 then read it back-to-back with no idle cycle
        req(1, 0, 32'h0000_0060, {16{16'h1111}});
        req(0, 0, 32'h0000_0060, '0);
        idle();

`ifdef PMEM_PROTOCOL_CHECK_EN
        // Address change during WAIT: error flag set, transaction completes on 0x100
        req(1, 0, 32'h0000_0100, {8{32'hC0DE_0100}});
        idle();
        req(1, 0, 32'h0000_0120, {8{32'hC0DE_0120}});
        idle();
        check("perr_clean", perr, 0);
        @(posedge clk); #1;
        rd = 1'b1; wr = 1'b0; addr = 32'h0000_0100;
        mon_e.due = cyc + LAT; mon_e.is_read = 1'b1; mon_e.data = model_mem[8];
        last_rd = model_mem[8];
        sb.push_back(mon_e);
        @(posedge clk); #1;
        addr = 32'h0000_0120;
        @(posedge clk);
        @(negedge clk);
        check("perr_set", perr, 1);
        wait_resp("perr_rd_timeout");
        idle();
        repeat (3) @(posedge clk);
        #1;
        check("perr_sticky", perr, 1);
`endif

        // Reset in the middle of a write: no commit, no response
        req(1, 0, 32'h0000_0080, {32{8'h22}});
        idle();
        @(posedge clk); #1;
        wr = 1'b1; rd = 1'b0; addr = 32'h0000_0080; wdata = {32{8'h33}};
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0; wr = 1'b0;
        #2;
        check("mid_rst_resp",  resp,  0);
        check("mid_rst_rdata", rdata, 0);
        check("mid_rst_perr",  perr,  0);
        last_rd = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        idle();
        req(0, 0, 32'h0000_0080, '0);
        idle();

        // Alias through the dropped upper bits, then write-over-read precedence
        req(1, 0, 32'h0000_0000, {16{16'hBEEF}});
        idle();
        req(0, 0, 32'h0000_2000, '0);
        idle();
        req(1, 1, 32'h0000_0040, {8{32'h5A5A_F00D}});
        idle();
        #1;
        check("both_perr", perr, EXP_BOTH_ERR);
        req(0, 0, 32'h0000_0040, '0);
        idle();

        // LATENCY=1: write, then a held read giving one response per 2 cycles
        bx = {4{64'h0123_4567_89AB_CDEF}};
        @(posedge clk); #1;
        b_wr = 1'b1; b_addr = 32'h0000_0020; b_wdata = bx;
        @(negedge clk);
        check("b_wr_capture_cycle", b_resp, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("b_wr_resp", b_resp, 1);
        check("b_wr_rdata_hold", b_rdata, 0);
        @(posedge clk); #1;
        b_wr = 1'b0; b_rd = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("b_rd_resp_pattern", b_resp, (i % 2 == 1) ? 1 : 0);
            if (i >= 1) check("b_rd_data", b_rdata, bx);
            @(posedge clk); #1;
        end
        b_rd = 1'b0;
        check("b_perr", b_perr, 0);

        repeat (4) @(posedge clk);
        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
